bit_serializer: RTL and testbench

- Upstream feeder for the "1101" sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them as a serial bit stream, one bit per enabled cycle.
- bit_out drives the detector's serial input; bit_valid qualifies each bit.
- Supports back-to-back words with no bubble, so a pattern spanning a word boundary is still delivered contiguously.

---
 rtl/bit_serializer_pkg.sv | 15 +
 rtl/bit_serializer.sv | 101 ++++++++++
 tb/tb_bit_serializer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared state encodings and sizing helper for the serial feeder.
// Optional parity slot is enabled with SER_PARITY_EN.
package bit_serializer_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_PAR   = 2'b11
   } ser_state_e;

   function automatic int ser_cnt_w(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with zero-gap back-to-back words.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             bit_en,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy
);

   localparam int            CW   = ser_cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   ser_state_e       r_state;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_cnt;
`ifdef SER_PARITY_EN
   logic             r_par;
`endif

   logic             w_head;
   logic             w_last;
   logic             w_load;
   logic [WIDTH-1:0] w_shift;

   assign w_head  = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
   assign w_shift = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                              : {1'b0, r_shreg[WIDTH-1:1]};
   assign w_last  = (r_state == S_SHIFT) && bit_en && (r_cnt == LAST);

`ifdef SER_PARITY_EN
   assign din_ready = (r_state == S_IDLE) ||
                      ((r_state == S_PAR) && bit_en);
`else
   assign din_ready = (r_state == S_IDLE) || w_last;
`endif

   assign w_load    = din_valid && din_ready;
   assign busy      = (r_state != S_IDLE);
   assign bit_valid = busy && bit_en;

   // Output bit comes only from registers, never from din.
   always_comb begin
      bit_out = 1'b0;
      case (r_state)
         S_SHIFT: bit_out = w_head;
`ifdef SER_PARITY_EN
         S_PAR:   bit_out = r_par;
`endif
         default: bit_out = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
`ifdef SER_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_load) begin
         r_state <= S_SHIFT;
         r_shreg <= din;
         r_cnt   <= '0;
`ifdef SER_PARITY_EN
         r_par   <= ^din;
`endif
      end else begin
         case (r_state)
            S_SHIFT: begin
               if (bit_en) begin
                  r_shreg <= w_shift;
                  r_cnt   <= r_cnt + 1'b1;
`ifdef SER_PARITY_EN
                  if (w_last) r_state <= S_PAR;
`else
                  if (w_last) r_state <= S_IDLE;
`endif
               end
            end
`ifdef SER_PARITY_EN
            S_PAR: begin
               if (bit_en) r_state <= S_IDLE;
            end
`endif
            default: r_state <= r_state;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer (MSB-first and LSB-first instances).
// Honours SER_PARITY_EN when the build defines it.
module tb_bit_serializer;

   localparam int W = 8;
`ifdef SER_PARITY_EN
   localparam int SLOTS = W + 1;
`else
   localparam int SLOTS = W;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         bit_en;
   logic         din_ready, bit_out, bit_valid, busy;
   logic         l_din_ready, l_bit_out, l_bit_valid, l_busy;

   int errors = 0;
   int checks = 0;
   bit q[$];

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .bit_en(bit_en), .bit_out(bit_out),
      .bit_valid(bit_valid), .busy(busy)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(l_din_ready), .bit_en(bit_en), .bit_out(l_bit_out),
      .bit_valid(l_bit_valid), .busy(l_busy)
   );

   function automatic void push_word(input logic [W-1:0] w, input bit msb);
      for (int i = 0; i < W; i++) q.push_back(msb ? w[W-1-i] : w[i]);
`ifdef SER_PARITY_EN
      q.push_back(^w);
`endif
   endfunction

   task automatic test_reset();
      rst = 1'b0; din = '0; din_valid = 1'b0; bit_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (bit_out !== 1'b0 || bit_valid !== 1'b0)
         begin errors++; $display("FAIL reset_bits: out=%b valid=%b want 0 0", bit_out, bit_valid); end
      checks++;
      if (busy !== 1'b0 || din_ready !== 1'b1)
         begin errors++; $display("FAIL reset_ctl: busy=%b ready=%b want 0 1", busy, din_ready); end
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || din_ready !== 1'b1)
         begin errors++; $display("FAIL idle_ctl: busy=%b ready=%b want 0 1", busy, din_ready); end
   endtask

   task automatic test_single();
      bit e;
      @(posedge clk); #1; din = 8'hD3; din_valid = 1'b1; bit_en = 1'b1;
      @(negedge clk);
      checks++;
      if (din_ready !== 1'b1)
         begin errors++; $display("FAIL single_accept: ready=%b want 1", din_ready); end
      push_word(8'hD3, 1'b1);
      for (int i = 1; i <= SLOTS; i++) begin
         @(posedge clk); #1; din_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (bit_valid !== 1'b1 || busy !== 1'b1)
            begin errors++; $display("FAIL single_vb[%0d]: valid=%b busy=%b want 1 1", i, bit_valid, busy); end
         checks++;
         if (q.size() == 0) begin errors++; $display("FAIL single_q[%0d]: scoreboard empty", i); end
         else begin
            e = q.pop_front();
            if (bit_out !== e)
               begin errors++; $display("FAIL single_bit[%0d]: got %b want %b", i, bit_out, e); end
         end
         checks++;
         if (din_ready !== 1'(i == SLOTS))
            begin errors++; $display("FAIL single_ready[%0d]: got %b want %b", i, din_ready, (i == SLOTS)); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || din_ready !== 1'b1 || bit_valid !== 1'b0)
         begin errors++; $display("FAIL single_done: busy=%b ready=%b valid=%b want 0 1 0", busy, din_ready, bit_valid); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] w[2];
      int idx = 0, nbits = 0, gaps = 0;
      bit e, done = 1'b0;
      w[0] = 8'h0D; w[1] = 8'hD0;
      @(posedge clk); #1; din = w[0]; din_valid = 1'b1; bit_en = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (bit_valid) begin
            nbits++;
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL b2b_q: extra bit %b", bit_out); end
            else begin
               e = q.pop_front();
               if (bit_out !== e)
                  begin errors++; $display("FAIL b2b_bit[%0d]: got %b want %b", nbits, bit_out, e); end
            end
         end else if (busy) gaps++;
         if (din_valid && din_ready && idx < 2) begin
            push_word(w[idx], 1'b1);
            idx++;
         end
         if (idx == 2 && q.size() == 0 && !busy) done = 1'b1;
         @(posedge clk); #1;
         din_valid = (idx < 2);
         din = (idx < 2) ? w[idx % 2] : '0;
      end
      din_valid = 1'b0;
      checks++;
      if (!done) begin errors++; $display("FAIL b2b_timeout: idx=%0d pending=%0d", idx, q.size()); end
      checks++;
      if (nbits != 2 * SLOTS)
         begin errors++; $display("FAIL b2b_count: got %0d want %0d", nbits, 2 * SLOTS); end
      checks++;
      if (gaps != 0) begin errors++; $display("FAIL b2b_gap: got %0d want 0", gaps); end
      q.delete();
   endtask

   task automatic test_bit_en();
      int en_seen = 0;
      bit e, done = 1'b0;
      @(posedge clk); #1; din = 8'hA5; din_valid = 1'b1; bit_en = 1'b1;
      @(negedge clk);
      push_word(8'hA5, 1'b1);
      for (int k = 1; k <= 40 && !done; k++) begin
         @(posedge clk); #1;
         din_valid = 1'b0;
         bit_en = ((k - 1) % 3 == 0);
         @(negedge clk);
         if (en_seen < SLOTS) begin
            checks++;
            if (busy !== 1'b1 || bit_valid !== bit_en)
               begin errors++; $display("FAIL en_vb[%0d]: busy=%b valid=%b want 1 %b", k, busy, bit_valid, bit_en); end
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL en_q[%0d]: scoreboard empty", k); end
            else begin
               e = bit_en ? q.pop_front() : q[0];
               if (bit_out !== e)
                  begin errors++; $display("FAIL en_bit[%0d]: got %b want %b", k, bit_out, e); end
            end
            if (bit_en) en_seen++;
         end else begin
            checks++;
            if (busy !== 1'b0 || bit_valid !== 1'b0)
               begin errors++; $display("FAIL en_done[%0d]: busy=%b valid=%b want 0 0", k, busy, bit_valid); end
            done = 1'b1;
         end
      end
      checks++;
      if (!done || q.size() != 0)
         begin errors++; $display("FAIL en_timeout: done=%b pending=%0d", done, q.size()); end
      bit_en = 1'b1;
      q.delete();
   endtask

   task automatic test_reset_mid();
      int stray = 0;
      bit e;
      @(posedge clk); #1; din = 8'hFF; din_valid = 1'b1; bit_en = 1'b1;
      @(negedge clk);
      push_word(8'hFF, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         din_valid = 1'b0;
         if (i == 4) rst = 1'b0;
         @(negedge clk);
         checks++;
         e = q.pop_front();
         if (bit_valid !== 1'b1 || bit_out !== e)
            begin errors++; $display("FAIL rmid_bit[%0d]: valid=%b out=%b want 1 %b", i, bit_valid, bit_out, e); end
      end
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bit_out !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1)
         begin errors++; $display("FAIL rmid_state: out=%b valid=%b busy=%b ready=%b want 0 0 0 1",
                                  bit_out, bit_valid, busy, din_ready); end
      q.delete();
      repeat (10) begin
         @(negedge clk);
         if (bit_valid || busy) stray++;
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL rmid_stray: got %0d want 0", stray); end
   endtask

   task automatic test_lsb();
      bit e;
      @(posedge clk); #1; din = 8'h0B; din_valid = 1'b1; bit_en = 1'b1;
      @(negedge clk);
      checks++;
      if (l_din_ready !== 1'b1)
         begin errors++; $display("FAIL lsb_accept: ready=%b want 1", l_din_ready); end
      push_word(8'h0B, 1'b0);
      for (int i = 1; i <= SLOTS; i++) begin
         @(posedge clk); #1; din_valid = 1'b0;
         @(negedge clk);
         checks++;
         e = q.pop_front();
         if (l_bit_valid !== 1'b1 || l_bit_out !== e)
            begin errors++; $display("FAIL lsb_bit[%0d]: valid=%b out=%b want 1 %b", i, l_bit_valid, l_bit_out, e); end
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (l_busy !== 1'b0 || l_din_ready !== 1'b1)
         begin errors++; $display("FAIL lsb_done: busy=%b ready=%b want 0 1", l_busy, l_din_ready); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_bit_en();
      test_reset_mid();
      test_lsb();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
